// File: rtl/div_seq.sv
// Iterative restoring divider for the execute stage: stalls the pipeline for W+2 cycles,
// then presents one registered {result, flags} with a single-cycle done pulse.
`timescale 1ns/1ps
module div_seq #(
  parameter int W  = 32,
  parameter int CW = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic         signed_i,
  input  logic         rem_i,
  input  logic [W-1:0] dest_i,
  input  logic [W-1:0] src_i,
  input  logic         flush_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [W-1:0] result_o,
  output logic [3:0]   flags_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

  logic [1:0]   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0] result_q, result_d;
  logic [3:0]   flags_q, flags_d;
  logic [W:0]   rem_q, rem_d;
  logic [W-1:0] quo_q, quo_d;
  logic [W-1:0] dvs_q, dvs_d;
  logic         qneg_q, qneg_d;
  logic         rneg_q, rneg_d;
  logic         remsel_q, remsel_d;

  logic         dvd_neg, dvs_neg;
  logic [W-1:0] dvd_mag, dvs_mag;
  logic [W:0]   shifted;
  logic         fits;
  logic [W-1:0] quo_fix, rem_fix;

  // {Z, N, V, DZ} derived from the value actually delivered
  function automatic logic [3:0] mk_flags(input logic [W-1:0] r, input logic v, input logic dz);
    return {(r == '0), r[W-1], v, dz};
  endfunction

  assign dvd_neg = signed_i & dest_i[W-1];
  assign dvs_neg = signed_i & src_i[W-1];
  assign dvd_mag = dvd_neg ? (~dest_i + 1'b1) : dest_i;
  assign dvs_mag = dvs_neg ? (~src_i + 1'b1) : src_i;

  // rem_q[W] only takes part in the compare; a partial remainder never exceeds W bits
  assign shifted = {rem_q[W-1:0], quo_q[W-1]};
  assign fits    = ({rem_q, quo_q[W-1]} >= {2'b00, dvs_q});
  assign quo_fix = qneg_q ? (~quo_q + 1'b1) : quo_q;
  assign rem_fix = rneg_q ? (~rem_q[W-1:0] + 1'b1) : rem_q[W-1:0];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    flags_d  = flags_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    remsel_d = remsel_q;
    if (flush_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            remsel_d = rem_i;
            qneg_d   = dvd_neg ^ dvs_neg;
            rneg_d   = dvd_neg;
            dvs_d    = dvs_mag;
            if (src_i == '0) begin
              result_d = rem_i ? dest_i : '1;
              flags_d  = mk_flags(result_d, 1'b0, 1'b1);
              state_d  = DONE;
            end else if (signed_i && dest_i == MIN_VAL && src_i == '1) begin
              result_d = rem_i ? '0 : MIN_VAL;
              flags_d  = mk_flags(result_d, 1'b1, 1'b0);
              state_d  = DONE;
            end else begin
              cnt_d   = CW'(W - 1);
              rem_d   = '0;
              quo_d   = dvd_mag;
              state_d = CALC;
            end
          end
        end
        CALC: begin
          rem_d = fits ? (shifted - {1'b0, dvs_q}) : shifted;
          quo_d = {quo_q[W-2:0], fits};
          if (cnt_q == '0) state_d = FIX;
          else cnt_d = cnt_q - 1'b1;
        end
        FIX: begin
          result_d = remsel_q ? rem_fix : quo_fix;
          flags_d  = mk_flags(result_d, 1'b0, 1'b0);
          state_d  = DONE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Control and delivered result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  // Iteration datapath, only meaningful once loaded from IDLE
  always_ff @(posedge clk) begin
    rem_q    <= rem_d;
    quo_q    <= quo_d;
    dvs_q    <= dvs_d;
    qneg_q   <= qneg_d;
    rneg_q   <= rneg_d;
    remsel_q <= remsel_d;
  end

  assign busy_o   = ((state_q == IDLE) & start_i & ~flush_i) | (state_q == CALC) | (state_q == FIX);
  assign done_o   = (state_q == DONE);
  assign result_o = result_q;
  assign flags_o  = flags_q;

endmodule
